// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
//   Synthesizable I2C target used as the bus partner for the APB-to-I2C
//   master. SCL/SDA are oversampled with core_clk, START/STOP and a 7-bit
//   address are decoded, and a small register file is served with
//   pointer-addressed, auto-incrementing writes and reads.
// Ports:
//   core_clk  sampling clock, all state changes on its rising edge
//   preset    asynchronous active-high reset
//   scl       I2C clock from the master (never stretched here)
//   sda       I2C data, open drain: driven 1'b0 or released to Z
//   busy      high from an addressed START until STOP
//   ptr       current register pointer
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16
) (
  input  logic                     core_clk,
  input  logic                     preset,
  input  logic                     scl,
  inout  wire                      sda,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] ptr
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WPTR, WPTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  state_t        state_reg, state_next;
  logic          scl_meta_reg, scl_sync_reg, scl_prev_reg;
  logic          sda_meta_reg, sda_sync_reg, sda_prev_reg;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    tx_reg, tx_next;
  logic          sda_oe_reg, sda_oe_next;
  logic          busy_reg, busy_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic          rw_reg, rw_next;
  logic          ack_reg, ack_next;
  logic [7:0]    regs [DEPTH];
  logic          wr_en;
  logic [7:0]    rx_byte, rd_byte;
  logic          scl_rise, scl_fall, start_evt, stop_evt;

  // Open-drain output straight from a flop, so reset releases SDA at once.
  assign sda  = sda_oe_reg ? 1'b0 : 1'bz;
  assign busy = busy_reg;
  assign ptr  = ptr_reg;

  assign scl_rise  =  scl_sync_reg & ~scl_prev_reg;
  assign scl_fall  = ~scl_sync_reg &  scl_prev_reg;
  assign start_evt =  scl_sync_reg &  sda_prev_reg & ~sda_sync_reg;
  assign stop_evt  =  scl_sync_reg & ~sda_prev_reg &  sda_sync_reg;
  assign rx_byte   = {shift_reg[6:0], sda_sync_reg};
  assign rd_byte   = regs[ptr_reg];

  always_ff @(posedge core_clk or posedge preset) begin
    if (preset) begin
      state_reg    <= IDLE;
      scl_meta_reg <= 1'b1;
      scl_sync_reg <= 1'b1;
      scl_prev_reg <= 1'b1;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= '0;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      ptr_reg      <= '0;
      rw_reg       <= 1'b0;
      ack_reg      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state_reg    <= state_next;
      scl_meta_reg <= scl;
      scl_sync_reg <= scl_meta_reg;
      scl_prev_reg <= scl_sync_reg;
      sda_meta_reg <= sda;
      sda_sync_reg <= sda_meta_reg;
      sda_prev_reg <= sda_sync_reg;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      sda_oe_reg   <= sda_oe_next;
      busy_reg     <= busy_next;
      ptr_reg      <= ptr_next;
      rw_reg       <= rw_next;
      ack_reg      <= ack_next;
      if (wr_en) regs[ptr_reg] <= rx_byte;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    sda_oe_next  = sda_oe_reg;
    busy_next    = busy_reg;
    ptr_next     = ptr_reg;
    rw_next      = rw_reg;
    ack_next     = ack_reg;
    wr_en        = 1'b0;

    // Bus conditions take priority over any bit edge seen in the same cycle.
    if (start_evt) begin
      bit_cnt_next = '0;
      shift_next   = '0;
      sda_oe_next  = 1'b0;
      state_next   = ADDR;
    end else if (stop_evt) begin
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        ADDR, WPTR, WDATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_next = '0;
              case (state_reg)
                ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    busy_next  = 1'b1;
                    rw_next    = rx_byte[0];
                    state_next = ADDR_ACK;
                  end else begin
                    state_next = IGNORE;
                  end
                end
                WPTR: begin
                  ptr_next   = rx_byte[PW-1:0];
                  state_next = WPTR_ACK;
                end
                default: begin
                  wr_en      = 1'b1;
                  ptr_next   = ptr_reg + 1'b1;
                  state_next = WDATA_ACK;
                end
              endcase
            end
          end
        end
        // First SCL fall (end of bit 8) starts the ACK pull-down; the second
        // (end of bit 9) releases it. sda_oe_reg doubles as the phase flag.
        ADDR_ACK, WPTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next = 1'b0;
              if (state_reg == ADDR_ACK && rw_reg) begin
                tx_next      = rd_byte;
                sda_oe_next  = ~rd_byte[7];
                bit_cnt_next = '0;
                state_next   = RDATA;
              end else if (state_reg == ADDR_ACK) begin
                state_next = WPTR;
              end else begin
                state_next = WDATA;
              end
            end
          end
        end
        // bit_cnt counts the rises the master has sampled; bit7 is already
        // on the wire when this state is entered.
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next = 1'b0;
              ptr_next    = ptr_reg + 1'b1;
              state_next  = RACK;
            end else begin
              tx_next     = {tx_reg[6:0], 1'b0};
              sda_oe_next = ~tx_reg[6];
            end
          end
        end
        // ACK/NACK is captured on the rise; the next byte goes out only after
        // the following fall so SDA never moves while SCL is high.
        RACK: begin
          if (scl_rise) begin
            ack_next = ~sda_sync_reg;
          end else if (scl_fall) begin
            if (ack_reg) begin
              tx_next      = rd_byte;
              sda_oe_next  = ~rd_byte[7];
              bit_cnt_next = '0;
              state_next   = RDATA;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master drives
// write, read, wrong-address, pointer-wrap and reset-during-read transfers
// and compares acks, read data, busy and ptr against hand-computed values.
module tb_i2c_slave_responder;
  logic       core_clk = 1'b0;
  logic       preset   = 1'b1;
  logic       scl      = 1'b1;
  logic       m_low    = 1'b0;
  wire        sda;
  wire        busy;
  wire  [3:0] ptr;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       a;
  logic [7:0] r0, r1;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 core_clk = ~core_clk;

  i2c_slave_responder #(.SLAVE_ADDR(7'h50), .DEPTH(16)) dut (
    .core_clk (core_clk),
    .preset   (preset),
    .scl      (scl),
    .sda      (sda),
    .busy     (busy),
    .ptr      (ptr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(8);
    m_low = 1'b1; wait_clk(8);
    scl   = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clk(4); m_low = 1'b0;
    wait_clk(4); scl   = 1'b1;
    wait_clk(8); m_low = 1'b1;
    wait_clk(8); scl   = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(4); m_low = 1'b1;
    wait_clk(4); scl   = 1'b1;
    wait_clk(8); m_low = 1'b0;
    wait_clk(8);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(4); m_low = ~b;
    wait_clk(4); scl   = 1'b1;
    wait_clk(8); scl   = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(8); scl = 1'b1;
    wait_clk(4); b   = sda;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    wait_clk(4); m_low = 1'b0;
    wait_clk(4); scl   = 1'b1;
    wait_clk(4); ack   = ~sda;
    wait_clk(4); scl   = 1'b0;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic b;
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    wait_clk(4); m_low = m_ack;
    wait_clk(4); scl   = 1'b1;
    wait_clk(8); scl   = 1'b0;
    wait_clk(2); m_low = 1'b0;
  endtask

  task automatic wr_regs(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1);
    logic ack;
    i2c_start();
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b1);
    check("wr_busy", busy, 1'b1);
    send_byte(p,  ack);    check("wr_ptr_ack", ack, 1'b1);
    send_byte(d0, ack);    check("wr_d0_ack", ack, 1'b1);
    send_byte(d1, ack);    check("wr_d1_ack", ack, 1'b1);
    i2c_stop();
    $display("txn write ptr=%02h data=%02h %02h -> ptr=%0d busy=%0d", p, d0, d1, ptr, busy);
  endtask

  task automatic rd_regs(input logic [7:0] p, output logic [7:0] d0, output logic [7:0] d1);
    logic ack;
    i2c_start();
    send_byte(8'hA0, ack); check("rd_waddr_ack", ack, 1'b1);
    send_byte(p, ack);     check("rd_ptr_ack", ack, 1'b1);
    i2c_rstart();
    send_byte(8'hA1, ack); check("rd_raddr_ack", ack, 1'b1);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    wait_clk(4);
    check("rd_sda_released", sda, 1'b1);
    i2c_stop();
    $display("txn read ptr=%02h -> data=%02h %02h ptr=%0d", p, d0, d1, ptr);
  endtask

  initial begin
    wait_clk(5);
    preset = 1'b0;
    wait_clk(10);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ptr", ptr, 4'd0);
    $display("txn reset -> sda=%0b busy=%0b ptr=%0d", sda, busy, ptr);

    // Fresh register file reads back zeros.
    rd_regs(8'h00, r0, r1);
    check("rst_reg0", r0, 8'h00);
    check("rst_reg1", r1, 8'h00);

    wr_regs(8'h03, 8'h11, 8'h22);
    check("wr_ptr_end", ptr, 4'd5);
    check("wr_busy_end", busy, 1'b0);

    rd_regs(8'h03, r0, r1);
    check("rd_reg3", r0, 8'h11);
    check("rd_reg4", r1, 8'h22);
    check("rd_ptr_end", ptr, 4'd5);

    // Wrong address: no ACK on either byte, nothing changes.
    i2c_start();
    send_byte(8'hB0, a); check("bad_addr_nack", a, 1'b0);
    check("bad_busy", busy, 1'b0);
    send_byte(8'h55, a); check("bad_data_nack", a, 1'b0);
    i2c_stop();
    check("bad_ptr", ptr, 4'd5);
    $display("txn wrong-addr 0xB0 -> busy=%0b ptr=%0d", busy, ptr);
    rd_regs(8'h03, r0, r1);
    check("bad_reg3", r0, 8'h11);
    check("bad_reg4", r1, 8'h22);

    // Pointer wrap from the last register to the first.
    wr_regs(8'h0F, 8'hAA, 8'hBB);
    check("wrap_ptr", ptr, 4'd1);
    rd_regs(8'h0F, r0, r1);
    check("wrap_reg15", r0, 8'hAA);
    check("wrap_reg0", r1, 8'hBB);
    check("wrap_rd_ptr", ptr, 4'd1);

    // Reset in the middle of a read byte of reg[0]=0xBB (bit7=1, bit6=0).
    i2c_start();
    send_byte(8'hA0, a); check("mid_waddr_ack", a, 1'b1);
    send_byte(8'h00, a); check("mid_ptr_ack", a, 1'b1);
    i2c_rstart();
    send_byte(8'hA1, a); check("mid_raddr_ack", a, 1'b1);
    m_low = 1'b0;
    read_bit(a);         check("mid_bit7", a, 1'b1);
    wait_clk(6);         check("mid_bit6_drive", sda, 1'b0);
    @(posedge core_clk); #1;
    preset = 1'b1;
    #1;
    check("mid_rst_sda", sda, 1'b1);
    check("mid_rst_ptr", ptr, 4'd0);
    check("mid_rst_busy", busy, 1'b0);
    $display("txn reset-in-read -> sda=%0b ptr=%0d busy=%0b", sda, ptr, busy);
    wait_clk(3);
    scl = 1'b1;
    wait_clk(2);
    preset = 1'b0;
    wait_clk(16);

    wr_regs(8'h08, 8'h5A, 8'hC3);
    check("post_ptr", ptr, 4'd10);
    rd_regs(8'h0F, r0, r1);
    check("post_reg15", r0, 8'h00);
    check("post_reg0", r1, 8'h00);
    rd_regs(8'h08, r0, r1);
    check("post_reg8", r0, 8'h5A);
    check("post_reg9", r1, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
